// File: rtl/usart_pkg.sv
// Shared encodings for the usart pattern generator: traffic modes and FSM states.
package usart_pkg;

  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_INC   = 2'b01;
  localparam logic [1:0] MODE_ECHO  = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_e;

endpackage

// File: rtl/usart_pattern_gen_if.sv
// UART transmit/receive handshake between the pattern generator (master) and the UART core (slave).
interface usart_pattern_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (output tx_data, output tx_start, input tx_busy, input rx_data, input rx_valid);
  modport slave  (input tx_data, input tx_start, output tx_busy, output rx_data, output rx_valid);
endinterface

// File: rtl/usart_echo_fifo.sv
// Synchronous echo FIFO; a push into a full FIFO without a same-cycle pop is dropped and sets a sticky flag.
module usart_echo_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              drop_flag
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              do_push, do_pop;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign drop_flag = drop_q;

  always_comb begin
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q | (push && !do_push);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/usart_pattern_gen.sv
// Bring-up traffic source for my_usart: fixed, incrementing or echoed bytes with a programmable gap.
//   state     | meaning
//   IDLE      | waiting for enable / data to send
//   LOAD      | sample mode, latch byte (pop echo FIFO)
//   START     | tx_start held until UART reports busy
//   WAIT_DONE | waiting for busy to fall, count the byte
//   GAP       | idle gap cycles before next byte
module usart_pattern_gen
  import usart_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter logic [DATA_W-1:0] FIXED_BYTE = DATA_W'(67),
  parameter int              ECHO_DEPTH = 16,
  parameter int              GAP_W      = 16,
  parameter int              CNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [GAP_W-1:0]   gap,
  usart_pattern_gen_if.master uart,
  output logic [CNT_W-1:0]   sent_count,
  output logic               overflow,
  output logic               active
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [CNT_W-1:0]    sent_count_q, sent_count_d;
  logic [DATA_W-1:0]   inc_byte_q, inc_byte_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic                active_q, active_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]   fifo_head;

  assign fifo_push = uart.rx_valid && (mode == MODE_ECHO);

  usart_echo_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (ECHO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (uart.rx_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop_flag (overflow)
  );

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = tx_start_q;
    sent_count_d = sent_count_q;
    inc_byte_d   = inc_byte_q;
    gap_cnt_d    = gap_cnt_q;
    mode_d       = mode_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && (mode != MODE_HOLD) && ((mode != MODE_ECHO) || !fifo_empty))
          state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // The mode seen here governs the whole byte, including the post-send increment.
        mode_d = mode;
        case (mode)
          MODE_FIXED: tx_data_d = FIXED_BYTE;
          MODE_INC:   tx_data_d = inc_byte_q;
          MODE_ECHO: begin
            tx_data_d = fifo_head;
            fifo_pop  = 1'b1;
          end
          default:    tx_data_d = tx_data_q;
        endcase
        tx_start_d = 1'b1;
        state_d    = ST_START;
      end
      ST_START: begin
        if (uart.tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart.tx_busy) begin
          sent_count_d = sent_count_q + CNT_W'(1);
          if (mode_q == MODE_INC) inc_byte_d = inc_byte_q + DATA_W'(1);
          if (gap == '0) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = gap;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      sent_count_q <= '0;
      inc_byte_q   <= '0;
      gap_cnt_q    <= '0;
      mode_q       <= MODE_FIXED;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      sent_count_q <= sent_count_d;
      inc_byte_q   <= inc_byte_d;
      gap_cnt_q    <= gap_cnt_d;
      mode_q       <= mode_d;
      active_q     <= active_d;
    end
  end

  assign uart.tx_data  = tx_data_q;
  assign uart.tx_start = tx_start_q;
  assign sent_count    = sent_count_q;
  assign active        = active_q;

endmodule

// File: tb/tb_usart_pattern_gen.sv
// Directed bench for usart_pattern_gen with a simple UART busy-response model.
module tb_usart_pattern_gen;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b11;
  logic [15:0] gap = '0;
  logic [15:0] sent_count;
  logic        overflow;
  logic        active;

  int checks = 0;
  int failures = 0;

  usart_pattern_gen_if #(.DATA_W(8)) uif ();

  usart_pattern_gen dut (
    .clock      (clock),
    .reset      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .gap        (gap),
    .uart       (uif),
    .sent_count (sent_count),
    .overflow   (overflow),
    .active     (active)
  );

  always #5 clock = ~clock;

  // UART model: busy rises a couple of cycles after tx_start, stays high 10 cycles.
  logic force_busy = 1'b0;
  int   m_dly, m_bsy;
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_dly <= 0;
      m_bsy <= 0;
      uif.tx_busy <= 1'b0;
    end else if (force_busy) begin
      uif.tx_busy <= 1'b1;
      m_bsy <= 1;
    end else if (m_bsy != 0) begin
      m_bsy <= m_bsy - 1;
      if (m_bsy == 1) uif.tx_busy <= 1'b0;
    end else if (m_dly != 0) begin
      m_dly <= m_dly - 1;
      if (m_dly == 1) begin
        uif.tx_busy <= 1'b1;
        m_bsy <= 10;
      end
    end else if (uif.tx_start && !uif.tx_busy) begin
      m_dly <= 2;
    end
  end

  // Byte capture at the handshake point, and measurement of the post-busy idle run
  // (one WAIT_DONE cycle plus the GAP cycles, until active falls).
  logic [7:0] cap[$];
  logic prev_busy = 1'b0;
  bit   counting = 1'b0;
  int   run_len = 0, mon_runs = 0, mon_bad = 0, exp_run = 1;
  always @(negedge clock) begin
    if (uif.tx_start && uif.tx_busy) cap.push_back(uif.tx_data);
    if (prev_busy && !uif.tx_busy) begin
      counting = 1'b1;
      run_len  = 0;
    end
    if (counting) begin
      if (!active) begin
        counting = 1'b0;
        mon_runs++;
        if (run_len != exp_run) mon_bad++;
      end else if (!uif.tx_start && !uif.tx_busy) begin
        run_len++;
      end
    end
    prev_busy = uif.tx_busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_count(input string tag, input logic [15:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (sent_count == target) break;
    end
    chk(tag, {16'h0, sent_count}, {16'h0, target});
  endtask

  task automatic push_byte(input logic [7:0] b);
    uif.rx_data  = b;
    uif.rx_valid = 1'b1;
    @(negedge clock);
    uif.rx_valid = 1'b0;
  endtask

  initial begin
    int bad;
    bit seen;
    uif.rx_data  = '0;
    uif.rx_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_tx_data", {24'h0, uif.tx_data}, 32'h0);
    chk("rst_tx_start", {31'h0, uif.tx_start}, 32'h0);
    chk("rst_sent_count", {16'h0, sent_count}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_active", {31'h0, active}, 32'h0);
    rst_n = 1'b1;
    @(negedge clock);

    // 1: fixed byte, gap 0
    exp_run = 1; mon_runs = 0; mon_bad = 0;
    mode = 2'b00; gap = 16'd0; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (uif.tx_start && uif.tx_busy) begin seen = 1'b1; break; end
    end
    chk("t1_handshake_seen", {31'h0, seen}, 32'h1);
    @(negedge clock);
    chk("t1_start_drop", {31'h0, uif.tx_start}, 32'h0);
    chk("t1_active_wait", {31'h0, active}, 32'h1);
    wait_count("t1_count", 16'd5, 200);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    chk("t1_nbytes", cap.size(), 32'd5);
    bad = 0;
    foreach (cap[i]) if (cap[i] !== 8'd67) bad++;
    chk("t1_bytes_67", bad, 32'd0);
    chk("t1_gap_runs", mon_runs, 32'd5);
    chk("t1_gap_bad", mon_bad, 32'd0);

    // 2: increment mode, gap 3, 258 transfers with wrap
    cap.delete();
    exp_run = 4; mon_runs = 0; mon_bad = 0;
    mode = 2'b01; gap = 16'd3; enable = 1'b1;
    wait_count("t2_count", 16'd263, 8000);
    enable = 1'b0;
    repeat (8) @(negedge clock);
    chk("t2_nbytes", cap.size(), 32'd258);
    bad = 0;
    foreach (cap[i]) if (cap[i] !== 8'(i)) bad++;
    chk("t2_bytes_seq", bad, 32'd0);
    if (cap.size() == 258) begin
      chk("t2_byte255", {24'h0, cap[255]}, 32'd255);
      chk("t2_byte256", {24'h0, cap[256]}, 32'd0);
      chk("t2_byte257", {24'h0, cap[257]}, 32'd1);
    end
    chk("t2_gap_runs", mon_runs, 32'd258);
    chk("t2_gap_bad", mon_bad, 32'd0);

    // 3: echo of three received bytes
    cap.delete();
    mode = 2'b10; gap = 16'd0; enable = 1'b1;
    push_byte(8'hA5);
    push_byte(8'h5A);
    push_byte(8'h3C);
    wait_count("t3_count", 16'd266, 300);
    repeat (5) @(negedge clock);
    chk("t3_idle_empty", {31'h0, active}, 32'h0);
    chk("t3_nbytes", cap.size(), 32'd3);
    if (cap.size() == 3) begin
      chk("t3_byte0", {24'h0, cap[0]}, 32'hA5);
      chk("t3_byte1", {24'h0, cap[1]}, 32'h5A);
      chk("t3_byte2", {24'h0, cap[2]}, 32'h3C);
    end
    chk("t3_overflow", {31'h0, overflow}, 32'h0);

    // 5: full FIFO, push in the same cycle as the LOAD pop
    cap.delete();
    enable = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    chk("t5_full_no_ovf", {31'h0, overflow}, 32'h0);
    enable = 1'b1;
    @(negedge clock);
    chk("t5_in_load", {31'h0, active}, 32'h1);
    push_byte(8'h77);
    chk("t5_simul_no_ovf", {31'h0, overflow}, 32'h0);
    wait_count("t5_count", 16'd283, 1000);
    repeat (5) @(negedge clock);
    chk("t5_nbytes", cap.size(), 32'd17);
    bad = 0;
    for (int i = 0; i < 16 && i < cap.size(); i++) if (cap[i] !== 8'h10 + 8'(i)) bad++;
    chk("t5_bytes_order", bad, 32'd0);
    if (cap.size() == 17) chk("t5_last_byte", {24'h0, cap[16]}, 32'h77);
    chk("t5_overflow_end", {31'h0, overflow}, 32'h0);
    chk("t5_idle", {31'h0, active}, 32'h0);

    // 4: busy held, 17 pushes into 16-entry FIFO
    cap.delete();
    enable = 1'b0;
    force_busy = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    chk("t4_16_no_ovf", {31'h0, overflow}, 32'h0);
    push_byte(8'h90);
    chk("t4_17_ovf", {31'h0, overflow}, 32'h1);
    force_busy = 1'b0;
    repeat (2) @(negedge clock);
    enable = 1'b1;
    wait_count("t4_count", 16'd299, 1000);
    repeat (8) @(negedge clock);
    chk("t4_nbytes", cap.size(), 32'd16);
    bad = 0;
    foreach (cap[i]) if (cap[i] !== 8'h80 + 8'(i)) bad++;
    chk("t4_bytes_order", bad, 32'd0);
    chk("t4_ovf_sticky", {31'h0, overflow}, 32'h1);
    chk("t4_idle", {31'h0, active}, 32'h0);

    // 6: async reset mid-START, then restart in increment mode
    mode = 2'b01; gap = 16'd0; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (uif.tx_start) begin seen = 1'b1; break; end
    end
    chk("t6_start_seen", {31'h0, seen}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_tx_start", {31'h0, uif.tx_start}, 32'h0);
    chk("t6_rst_active", {31'h0, active}, 32'h0);
    chk("t6_rst_count", {16'h0, sent_count}, 32'h0);
    chk("t6_rst_overflow", {31'h0, overflow}, 32'h0);
    @(negedge clock);
    cap.delete();
    rst_n = 1'b1;
    @(negedge clock);
    chk("t6_lat_load", {31'h0, uif.tx_start}, 32'h0);
    @(negedge clock);
    chk("t6_lat_start", {31'h0, uif.tx_start}, 32'h1);
    wait_count("t6_count", 16'd1, 100);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    chk("t6_nbytes", cap.size(), 32'd1);
    if (cap.size() >= 1) chk("t6_first_byte", {24'h0, cap[0]}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
